// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter granting four requesters access to one register-file read port.
// Optional RF_ZERO_BYPASS_EN: reads of index 0 return zero without using Dout.
module rf_port_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [3:0]        Req,
  input  logic [4:0]        Addr0,
  input  logic [4:0]        Addr1,
  input  logic [4:0]        Addr2,
  input  logic [4:0]        Addr3,
  output logic [4:0]        Sel,
  input  logic [DATA_W-1:0] Dout,
  output logic [3:0]        Gnt,
  output logic [3:0]        Rvalid,
  output logic [DATA_W-1:0] Rdata,
  output logic              Busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        win_q, win_d;
  logic [4:0]        sel_q, sel_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [3:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef RF_ZERO_BYPASS_EN
  logic              zero_q, zero_d;
`endif

  logic [1:0] win_idx;
  logic [4:0] win_addr;

  // Scan from the farthest offset down so the nearest set request to ptr_q wins.
  always_comb begin
    win_idx = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (Req[ptr_q + 2'(i)]) win_idx = ptr_q + 2'(i);
    end
  end

  always_comb begin
    unique case (win_idx)
      2'd0:    win_addr = Addr0;
      2'd1:    win_addr = Addr1;
      2'd2:    win_addr = Addr2;
      default: win_addr = Addr3;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
`ifdef RF_ZERO_BYPASS_EN
    zero_d   = zero_q;
`endif
    unique case (state_q)
      StIdle, StResp: begin
        rvalid_d = 4'b0000;
        if (|Req) begin
          state_d = StRead;
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_addr;
          win_d   = win_idx;
          ptr_d   = win_idx + 2'd1;
`ifdef RF_ZERO_BYPASS_EN
          zero_d  = (win_addr == 5'd0);
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StRead: begin
        state_d  = StResp;
        gnt_d    = 4'b0000;
        rvalid_d = 4'b0001 << win_q;
`ifdef RF_ZERO_BYPASS_EN
        rdata_d  = zero_q ? '0 : Dout;
`else
        rdata_d  = Dout;
`endif
      end
      default: begin
        state_d  = StIdle;
        gnt_d    = 4'b0000;
        rvalid_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= 2'd0;
      win_q    <= 2'd0;
      sel_q    <= 5'd0;
      gnt_q    <= 4'b0000;
      rvalid_q <= 4'b0000;
      rdata_q  <= '0;
`ifdef RF_ZERO_BYPASS_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
`ifdef RF_ZERO_BYPASS_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign Sel    = sel_q;
  assign Gnt    = gnt_q;
  assign Rvalid = rvalid_q;
  assign Rdata  = rdata_q;
  assign Busy   = (state_q != StIdle);

endmodule
